// File: rtl/dpram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpram_arb_pkg
// Purpose  : Shared constants for the dual-port RAM port arbiter: the
//            arbitration FSM state encoding and the read-response latency.
// Config   : DPRAM_ARB_RSP_REG_EN -- when defined, adds one output register
//            stage to the read response (latency 2 instead of 1).
// Revision : 1.0 - initial release
// ============================================================================
package dpram_arb_pkg;

    // Arbitration FSM encoding
    localparam int                   c_STATE_W   = 1;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE   = 1'b0;  // free round-robin arbitration
    localparam logic [c_STATE_W-1:0] c_ST_LOCKED = 1'b1;  // grant pinned to the lock owner

    // Cycles from a transferred read beat to its rsp_valid strobe.
    // The RAM itself contributes one cycle; the optional stage adds one more.
`ifdef DPRAM_ARB_RSP_REG_EN
    localparam int c_RSP_LAT = 2;
`else
    localparam int c_RSP_LAT = 1;
`endif

endpackage
`default_nettype wire

// File: rtl/dpram_port_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin selector. Searches the request vector
//            starting one past the last granted index, wrapping modulo
//            NUM_REQ, and returns a one-hot grant (all zero if no request).
// Ports    : i_req        - request vector
//            i_last_grant - index of the most recently granted requester
//            o_grant      - one-hot grant
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant
);

    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dpram_port_arbiter
// Purpose  : Shares one port of a dual-port RAM among NUM_REQ requesters.
//            One beat per cycle, round-robin selection, optional lock that
//            pins the grant to one requester across beats, and read
//            responses tagged back to the issuing requester.
// Ports    : clk, reset (async, active high)
//            req_valid/req_ready/req_we/req_lock  - per-requester handshake
//            req_addr/req_byteen/req_wdata        - packed per-requester fields
//            rsp_valid (per requester), rsp_rdata (shared)
//            ram_address/ram_wren/ram_byteen/ram_data -> RAM port, ram_out <- RAM
// Config   : DPRAM_ARB_RSP_REG_EN -- registers rsp_valid/rsp_rdata one extra
//            stage (read latency 2); default read latency is 1.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int AWIDTH  = 10,
    parameter int DWIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*AWIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*DWIDTH/8-1:0]   req_byteen,
    input  logic [NUM_REQ*DWIDTH-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DWIDTH-1:0]             rsp_rdata,
    output logic [AWIDTH-1:0]             ram_address,
    output logic                          ram_wren,
    output logic [DWIDTH/8-1:0]           ram_byteen,
    output logic [DWIDTH-1:0]             ram_data,
    input  logic [DWIDTH-1:0]             ram_out
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_BW    = DWIDTH / 8;

    logic [c_STATE_W-1:0] r_state;
    logic [c_IDX_W-1:0]   r_lock_owner;
    logic [c_IDX_W-1:0]   r_last_grant;
    logic [NUM_REQ-1:0]   r_rd_tag;       // one-hot owner of the read now leaving the RAM
    logic [DWIDTH-1:0]    r_rdata_hold;   // last delivered read data

    logic [NUM_REQ-1:0]   w_owner_mask;
    logic [NUM_REQ-1:0]   w_req_eff;
    logic [NUM_REQ-1:0]   w_grant;
    logic [c_IDX_W-1:0]   w_gidx;
    logic                 w_fire;
    logic                 w_rd_fire;

    // While locked, everyone but the owner is masked out, so the arbiter
    // either grants the owner or nobody.
    always_comb begin
        w_owner_mask               = '0;
        w_owner_mask[r_lock_owner] = 1'b1;
        w_req_eff                  = req_valid;
        if (r_state == c_ST_LOCKED) begin
            w_req_eff = req_valid & w_owner_mask;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_arbiter (
        .i_req        (w_req_eff),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gidx = c_IDX_W'(i);
            end
        end
    end

    // Grants only ever go to valid requesters, so any ready bit is a beat.
    assign req_ready = reset ? '0 : w_grant;
    assign w_fire    = |req_ready;
    assign w_rd_fire = w_fire & ~req_we[w_gidx];

    assign ram_address = req_addr  [int'(w_gidx)*AWIDTH +: AWIDTH];
    assign ram_byteen  = req_byteen[int'(w_gidx)*c_BW   +: c_BW];
    assign ram_data    = req_wdata [int'(w_gidx)*DWIDTH +: DWIDTH];
    assign ram_wren    = w_fire & req_we[w_gidx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_lock_owner <= '0;
            r_last_grant <= c_IDX_W'(NUM_REQ - 1);
            r_rd_tag     <= '0;
            r_rdata_hold <= '0;
        end else begin
            r_rd_tag <= w_rd_fire ? w_grant : '0;
            if (|r_rd_tag) begin
                r_rdata_hold <= ram_out;
            end
            if (w_fire) begin
                r_last_grant <= w_gidx;
                case (r_state)
                    c_ST_IDLE: begin
                        if (req_lock[w_gidx]) begin
                            r_state      <= c_ST_LOCKED;
                            r_lock_owner <= w_gidx;
                        end
                    end
                    c_ST_LOCKED: begin
                        if (!req_lock[w_gidx]) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    if (c_RSP_LAT > 1) begin : g_rsp_reg
        // Extra stage: the hold register already captures ram_out on the
        // edge where the registered strobe rises, so it doubles as the
        // output data register.
        logic [NUM_REQ-1:0] r_rsp_valid;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_rsp_valid <= '0;
            end else begin
                r_rsp_valid <= r_rd_tag;
            end
        end

        assign rsp_valid = r_rsp_valid;
        assign rsp_rdata = r_rdata_hold;
    end else begin : g_rsp_comb
        // RAM output passes straight through during the strobe and the
        // held copy keeps the bus steady between responses.
        assign rsp_valid = r_rd_tag;
        assign rsp_rdata = (|r_rd_tag) ? ram_out : r_rdata_hold;
    end

endmodule
`default_nettype wire

// File: tb/tb_dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_port_arbiter
// Purpose  : Self-checking bench for dpram_port_arbiter. A RAM model with
//            one cycle read latency sits on the RAM port. A behavioural
//            reference (round-robin over requester indices, lock flag,
//            queue of pending read responses, shadow memory) is compared
//            against the DUT every cycle; directed sequences add literal
//            expectations. Honours DPRAM_ARB_RSP_REG_EN for latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;
`ifdef DPRAM_ARB_RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid, req_we, req_lock;
    logic [N*AW-1:0]   req_addr;
    logic [N*BW-1:0]   req_byteen;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_ready, rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [AW-1:0]     ram_address;
    logic              ram_wren;
    logic [BW-1:0]     ram_byteen;
    logic [DW-1:0]     ram_data;
    logic [DW-1:0]     ram_out;

    int tests = 0;
    int fails = 0;

    dpram_port_arbiter #(.NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_lock    (req_lock),
        .req_addr    (req_addr),
        .req_byteen  (req_byteen),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .ram_address (ram_address),
        .ram_wren    (ram_wren),
        .ram_byteen  (ram_byteen),
        .ram_data    (ram_data),
        .ram_out     (ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM port model: byte-enabled write, registered read
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_wren) begin
            for (int b = 0; b < BW; b++)
                if (ram_byteen[b]) mem[ram_address][8*b +: 8] <= ram_data[8*b +: 8];
        end
        ram_out <= mem[ram_address];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    typedef struct { int due; int id; logic [DW-1:0] data; } rsp_t;
    rsp_t          m_q[$];
    logic [DW-1:0] m_shadow [0:(1<<AW)-1];
    int            m_last   = N - 1;
    bit            m_locked = 0;
    int            m_owner  = 0;
    logic [DW-1:0] m_rdata  = '0;
    int            cyc      = 0;

    initial for (int i = 0; i < (1<<AW); i++) m_shadow[i] = '0;

    always @(negedge clk) begin : model
        int            g;
        logic [N-1:0]  exp_rsp, exp_rdy;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] be;
        if (reset) begin
            m_last = N - 1; m_locked = 0; m_owner = 0; m_rdata = '0;
            m_q.delete();
            check("rst_ready", req_ready, 0);
            check("rst_wren",  ram_wren, 0);
            check("rst_rspv",  rsp_valid, 0);
            check("rst_rdata", rsp_rdata, 0);
        end else begin
            exp_rsp = '0;
            if (m_q.size() > 0 && m_q[0].due == cyc) begin
                exp_rsp[m_q[0].id] = 1'b1;
                m_rdata = m_q[0].data;
                void'(m_q.pop_front());
            end
            check("rsp_valid", rsp_valid, exp_rsp);
            check("rsp_rdata", rsp_rdata, m_rdata);

            g = -1;
            if (m_locked) begin
                if (req_valid[m_owner]) g = m_owner;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", req_ready, exp_rdy);
            check("ram_wren", ram_wren, (g >= 0) ? req_we[g] : 1'b0);
            if (g >= 0) begin
                a  = req_addr[g*AW +: AW];
                d  = req_wdata[g*DW +: DW];
                be = req_byteen[g*BW +: BW];
                check("ram_address", ram_address, a);
                m_last = g;
                if (m_locked && !req_lock[g]) m_locked = 0;
                else if (!m_locked && req_lock[g]) begin m_locked = 1; m_owner = g; end
                if (req_we[g]) begin
                    check("ram_data", ram_data, d);
                    check("ram_byteen", ram_byteen, be);
                    for (int b = 0; b < BW; b++)
                        if (be[b]) m_shadow[a][8*b +: 8] = d[8*b +: 8];
                end else begin
                    m_q.push_back('{due: cyc + LAT, id: g, data: m_shadow[a]});
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                           input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_we[i]              = we;
        req_lock[i]            = lk;
        req_addr[i*AW +: AW]   = a;
        req_byteen[i*BW +: BW] = be;
        req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_we = '0; req_lock = '0;
        req_addr = '0; req_byteen = '0; req_wdata = '0;
    endtask

    logic [N-1:0] seq32 [4];

    initial begin
        reset = 1'b1;
        clear_reqs();
        seq32[0] = 3'b001; seq32[1] = 3'b010; seq32[2] = 3'b100; seq32[3] = 3'b001;
        repeat (2) tick();
        @(negedge clk);
        check("lit_rst_ready", req_ready, 0);
        check("lit_rst_rdata", rsp_rdata, 0);
        tick();
        reset = 1'b0;

        // Round-robin over three readers, responses one-hot after LAT cycles
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, AW'(i), '1, '0);
        for (int k = 0; k < 4 + LAT; k++) begin
            if (k >= 4) req_valid = '0;
            @(negedge clk);
            if (k < 4)    check("lit_rr_grant", req_ready, seq32[k]);
            if (k >= LAT) check("lit_rr_rsp", rsp_valid, seq32[k-LAT]);
            tick();
        end

        // Full write then read-back, partial write then read-back
        clear_reqs();
        set_req(1, 1, 1, 0, 10'd5, 4'b1111, 32'hDEADBEEF);
        @(negedge clk); check("lit_wr_grant", req_ready, 3'b010); tick();
        clear_reqs();
        set_req(2, 1, 0, 0, 10'd5, 4'b0000, '0);
        @(negedge clk); check("lit_rd_grant", req_ready, 3'b100); tick();
        req_valid = '0;
        repeat (LAT - 1) @(negedge clk);
        @(negedge clk);
        check("lit_rd_valid", rsp_valid, 3'b100);
        check("lit_rd_data", rsp_rdata, 32'hDEADBEEF);
        tick();
        set_req(1, 1, 1, 0, 10'd5, 4'b0001, 32'h00000011);
        @(negedge clk); tick();
        clear_reqs();
        set_req(2, 1, 0, 0, 10'd5, 4'b0000, '0);
        @(negedge clk); tick();
        req_valid = '0;
        repeat (LAT - 1) @(negedge clk);
        @(negedge clk);
        check("lit_part_data", rsp_rdata, 32'hDEADBE11);
        tick();

        // Locked burst from requester 0 while 1 and 2 wait
        clear_reqs();
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1, 0, (k < 3), AW'(k), '0, '0);
            set_req(1, 1, 0, 0, 10'd1, '0, '0);
            set_req(2, 1, 0, 0, 10'd2, '0, '0);
            @(negedge clk); check("lit_lock_grant", req_ready, 3'b001); tick();
        end
        req_valid[0] = 1'b0;
        @(negedge clk); check("lit_after_lock1", req_ready, 3'b010); tick();
        @(negedge clk); check("lit_after_lock2", req_ready, 3'b100); tick();
        req_valid = '0;
        tick();

        // Owner goes quiet while locked: nobody else gets in
        set_req(0, 1, 0, 1, 10'd7, '0, '0);
        @(negedge clk); check("lit_lk_take", req_ready, 3'b001); tick();
        req_valid = 3'b110;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); check("lit_lk_idle", req_ready, 3'b000); tick();
        end
        set_req(0, 1, 0, 0, 10'd7, '0, '0);
        @(negedge clk); check("lit_lk_resume", req_ready, 3'b001); tick();
        req_valid[0] = 1'b0;
        @(negedge clk); check("lit_lk_release", req_ready, 3'b010); tick();
        req_valid = '0;
        repeat (3) tick();

        // Reset right after a read beat drops the response
        clear_reqs();
        set_req(1, 1, 0, 0, 10'd5, '0, '0);
        @(negedge clk); check("lit_pre_rst_grant", req_ready, 3'b010);
        @(posedge clk); #1;
        reset = 1'b1;
        req_valid = '0;
        @(negedge clk); check("lit_rst_drop1", rsp_valid, 3'b000); tick();
        @(negedge clk); check("lit_rst_drop2", rsp_valid, 3'b000); tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, AW'(i), '0, '0);
        @(negedge clk);
        check("lit_post_rst_grant", req_ready, 3'b001);
        check("lit_post_rst_rsp", rsp_valid, 3'b000);
        tick();
        req_valid = '0;
        repeat (3) tick();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                        1'($urandom_range(0, 3) == 0), AW'($urandom_range(0, 15)),
                        BW'($urandom), DW'($urandom));
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0;
        clear_reqs();
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dpram_port_arbiter.md
DPRAM_PORT_ARBITER -- requirements
Module: dpram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of requesters sharing one RAM port (2..8).
REQ-002 SHALL have parameter AWIDTH, default 10, word address width.
REQ-003 SHALL have parameter DWIDTH, default 32, data width, multiple of 32.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester request accepted this cycle.
REQ-008 SHALL have port req_we  input  NUM_REQ  per-requester write (1) / read (0).
REQ-009 SHALL have port req_lock  input  NUM_REQ  hold the grant after this beat.
REQ-010 SHALL have port req_addr  input  NUM_REQ*AWIDTH  packed addresses, requester i at slice i.
REQ-011 SHALL have port req_byteen  input  NUM_REQ*DWIDTH/8  packed byte enables.
REQ-012 SHALL have port req_wdata  input  NUM_REQ*DWIDTH  packed write data.
REQ-013 SHALL have port rsp_valid  output  NUM_REQ  one-cycle read-data strobe per requester.
REQ-014 SHALL have port rsp_rdata  output  DWIDTH  read data, shared, qualified by rsp_valid.
REQ-015 SHALL have ports ram_address, ram_wren, ram_byteen, ram_data (outputs, AWIDTH/1/DWIDTH/8/DWIDTH) and ram_out (input, DWIDTH), connecting to one port of the dual-port RAM.

Function
REQ-016 SHALL accept at most one request per cycle: the granted requester i sees req_ready[i]=1 in the same cycle req_valid[i]=1; a beat transfers when valid&&ready.
REQ-017 SHALL drive ram_* combinationally from the granted requester's fields; ram_wren=0 when no beat transfers.
REQ-018 SHALL select among valid requesters round-robin: priority starts at index (last_grant+1) mod NUM_REQ; last_grant updates only on a transferred beat.
REQ-019 SHALL implement FSM states IDLE (free arbitration) and LOCKED (grant fixed to lock_owner).
REQ-020 SHALL go IDLE->LOCKED when a transferred beat has req_lock=1, recording lock_owner.
REQ-021 SHALL in LOCKED grant only lock_owner; go LOCKED->IDLE after a transferred beat with req_lock=0; stay LOCKED while lock_owner idles (req_valid=0).
REQ-022 SHALL, for a transferred read, assert rsp_valid[i] for exactly one cycle with ram_out on rsp_rdata, 1 cycle after the beat (RAM read latency 1); writes produce no response.
REQ-023 SHALL sustain one beat per cycle, including back-to-back reads from different requesters, each response tagged with its own requester.
REQ-024 SHALL never assert more than one bit of req_ready or rsp_valid in a cycle.
REQ-025 SHALL keep rsp_rdata stable between responses (no update without rsp_valid).

Reset
REQ-026 SHALL on reset asynchronously force: state=IDLE, last_grant=NUM_REQ-1 (requester 0 first), lock_owner=0, response tag pipeline empty, rsp_valid=0, rsp_rdata=0.
REQ-027 SHALL drop in-flight read responses if reset asserts mid-operation; none emitted after deassertion.
REQ-028 SHALL drive req_ready=0 and ram_wren=0 while reset is high.

Configuration
REQ-029 SHALL, with macro DPRAM_ARB_RSP_REG_EN defined, register rsp_valid/rsp_rdata one extra stage (read latency 2, throughput unchanged); without it, latency 1 per REQ-022.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE, LOCKED) and latency constants in shared package dpram_arb_pkg.
REQ-031 SHALL instantiate sub-module rr_arbiter (request vector, last_grant in; one-hot grant out) for REQ-018.

Verification
REQ-032 Reset then req_valid=3'b111, all reads, locks 0 -> grants 0,1,2,0 on successive cycles; rsp_valid one-hot 1 cycle later each.
REQ-033 Requester 1 writes addr 5 data 0xDEADBEEF byteen 4'b1111, then requester 2 reads addr 5 -> rsp_valid[2]=1, rsp_rdata=0xDEADBEEF; partial byteen 4'b0001 write 0x11 -> read 0xDEADBE11.
REQ-034 Requester 0 issues 4 beats with req_lock=1,1,1,0 while 1,2 valid -> 0 granted for all 4, then 1, then 2.
REQ-035 LOCKED owner drops req_valid 3 cycles while others valid -> no grants; owner resumes and completes.
REQ-036 Reset asserted cycle after read beat -> rsp_valid stays 0; first post-reset grant to requester 0.
REQ-037 Rerun REQ-032 with DPRAM_ARB_RSP_REG_EN -> same data/order, responses 2 cycles after beats.
